morse_encode_word_tx: RTL and testbench

Morse transmitter, the inverse of the capture/decode-word chain. It accepts a packed word of up to MAX_CHARS characters, encodes each character into a dit/dah pattern, and drives a single-bit keyed signal. Mark and space durations come from the same run-time timing inputs the receiver uses (dit_time, dah_time, word_time). It sits beside the receiver so the two can be looped back for self-test.

---
 rtl/morse_encode_word_tx.sv | 216 +++++++++++++++++++++
 tb/tb_morse_encode_word_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/morse_encode_word_tx.sv
// Morse word transmitter: walks a latched word one character at a time, looks each one up
// in an ITU dit/dah table and keys a single-bit mark/space output from run-time durations.
module morse_encode_word_tx #(
  parameter int PULSE_CNT_W   = 16,
  parameter int CHAR_W        = 8,
  parameter int MAX_CHARS     = 8,
  parameter int MAX_MORSE_LEN = 6
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          ce,
  input  logic [PULSE_CNT_W-1:0]        dit_time,
  input  logic [PULSE_CNT_W-1:0]        dah_time,
  input  logic [PULSE_CNT_W-1:0]        word_time,
  input  logic [CHAR_W*MAX_CHARS-1:0]   word,
  input  logic                          start,
  output logic                          busy,
  output logic                          signal,
  output logic                          done,
  output logic                          error
);

  localparam int IDX_W = $clog2(MAX_CHARS + 1);
  localparam int LEN_W = $clog2(MAX_MORSE_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, GAP_SYM, GAP_CHAR, GAP_WORD, DONE} state_t;

  state_t                       state_reg, state_next;
  logic [CHAR_W*MAX_CHARS-1:0]  word_reg, word_next;
  logic [IDX_W-1:0]             idx_reg, idx_next;
  logic [MAX_MORSE_LEN-1:0]     pat_reg, pat_next;
  logic [LEN_W-1:0]             left_reg, left_next;
  logic [PULSE_CNT_W-1:0]       cnt_reg, cnt_next;
  logic                         sent_reg, sent_next;
  logic                         error_reg, error_next;
  logic                         signal_reg;

  logic [CHAR_W-1:0]            chars [MAX_CHARS];
  logic [CHAR_W-1:0]            cur_char, peek_char;
  logic [IDX_W-1:0]             idx_inc;
  logic [9:0]                   cur_lut;
  logic [PULSE_CNT_W-1:0]       cur_dur;
  logic                         timed, phase_end, peek_end;

  generate
    for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_chars
      assign chars[gi] = word_reg[CHAR_W*gi +: CHAR_W];
    end
  endgenerate

  // Returns {supported, len[2:0], pattern[5:0]}; pattern bit0 goes out first, 1 = dah.
  function automatic logic [9:0] morse_lut(input logic [CHAR_W-1:0] c);
    logic [7:0] c8;
    logic [9:0] r;
    c8 = c[7:0];
    case (c8)
      8'h41: r = {1'b1, 3'd2, 6'b000010};  // A
      8'h42: r = {1'b1, 3'd4, 6'b000001};
      8'h43: r = {1'b1, 3'd4, 6'b000101};
      8'h44: r = {1'b1, 3'd3, 6'b000001};
      8'h45: r = {1'b1, 3'd1, 6'b000000};
      8'h46: r = {1'b1, 3'd4, 6'b000100};
      8'h47: r = {1'b1, 3'd3, 6'b000011};
      8'h48: r = {1'b1, 3'd4, 6'b000000};
      8'h49: r = {1'b1, 3'd2, 6'b000000};
      8'h4A: r = {1'b1, 3'd4, 6'b001110};
      8'h4B: r = {1'b1, 3'd3, 6'b000101};
      8'h4C: r = {1'b1, 3'd4, 6'b000010};
      8'h4D: r = {1'b1, 3'd2, 6'b000011};
      8'h4E: r = {1'b1, 3'd2, 6'b000001};
      8'h4F: r = {1'b1, 3'd3, 6'b000111};
      8'h50: r = {1'b1, 3'd4, 6'b000110};
      8'h51: r = {1'b1, 3'd4, 6'b001011};
      8'h52: r = {1'b1, 3'd3, 6'b000010};
      8'h53: r = {1'b1, 3'd3, 6'b000000};
      8'h54: r = {1'b1, 3'd1, 6'b000001};
      8'h55: r = {1'b1, 3'd3, 6'b000100};
      8'h56: r = {1'b1, 3'd4, 6'b001000};
      8'h57: r = {1'b1, 3'd3, 6'b000110};
      8'h58: r = {1'b1, 3'd4, 6'b001001};
      8'h59: r = {1'b1, 3'd4, 6'b001101};
      8'h5A: r = {1'b1, 3'd4, 6'b000011};
      8'h30: r = {1'b1, 3'd5, 6'b011111};  // 0
      8'h31: r = {1'b1, 3'd5, 6'b011110};
      8'h32: r = {1'b1, 3'd5, 6'b011100};
      8'h33: r = {1'b1, 3'd5, 6'b011000};
      8'h34: r = {1'b1, 3'd5, 6'b010000};
      8'h35: r = {1'b1, 3'd5, 6'b000000};
      8'h36: r = {1'b1, 3'd5, 6'b000001};
      8'h37: r = {1'b1, 3'd5, 6'b000011};
      8'h38: r = {1'b1, 3'd5, 6'b000111};
      8'h39: r = {1'b1, 3'd5, 6'b001111};
      8'h2E: r = {1'b1, 3'd6, 6'b101010};  // .
      8'h2C: r = {1'b1, 3'd6, 6'b110011};  // ,
      8'h3F: r = {1'b1, 3'd6, 6'b001100};  // ?
      8'h2F: r = {1'b1, 3'd5, 6'b001001};  // /
      8'h3D: r = {1'b1, 3'd5, 6'b010001};  // =
      default: r = 10'd0;
    endcase
    if ((c >> 8) != '0) r = 10'd0;
    return r;
  endfunction

  function automatic logic [PULSE_CNT_W-1:0] at_least_one(input logic [PULSE_CNT_W-1:0] t);
    return (t == '0) ? PULSE_CNT_W'(1) : t;
  endfunction

  always_comb begin
    idx_inc   = idx_reg + IDX_W'(1);
    cur_char  = '0;
    peek_char = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (idx_reg == IDX_W'(i)) cur_char = chars[i];
      if (idx_inc == IDX_W'(i)) peek_char = chars[i];
    end
    cur_lut  = morse_lut(cur_char);
    peek_end = (idx_inc == IDX_W'(MAX_CHARS)) || (peek_char == '0);

    timed = 1'b1;
    case (state_reg)
      MARK:     cur_dur = at_least_one(pat_reg[0] ? dah_time : dit_time);
      GAP_SYM:  cur_dur = at_least_one(dit_time);
      GAP_CHAR: cur_dur = at_least_one(dah_time);
      GAP_WORD: cur_dur = at_least_one(word_time);
      default: begin
        cur_dur = PULSE_CNT_W'(1);
        timed   = 1'b0;
      end
    endcase
    phase_end = timed && ce && (cnt_reg == cur_dur - PULSE_CNT_W'(1));
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    idx_next   = idx_reg;
    pat_next   = pat_reg;
    left_next  = left_reg;
    cnt_next   = cnt_reg;
    sent_next  = sent_reg;
    error_next = error_reg;

    if (timed && ce) cnt_next = phase_end ? '0 : cnt_reg + PULSE_CNT_W'(1);

    case (state_reg)
      IDLE: if (start) begin
        word_next  = word;
        idx_next   = '0;
        cnt_next   = '0;
        sent_next  = 1'b0;
        error_next = 1'b0;
        state_next = LOAD;
      end
      LOAD: begin
        if (idx_reg == IDX_W'(MAX_CHARS) || cur_char == '0) begin
          state_next = sent_reg ? GAP_WORD : DONE;
        end else if (!cur_lut[9]) begin
          error_next = 1'b1;
          idx_next   = idx_inc;
        end else begin
          left_next  = LEN_W'(cur_lut[8:6]);
          pat_next   = MAX_MORSE_LEN'(cur_lut[5:0]);
          sent_next  = 1'b1;
          state_next = MARK;
        end
      end
      // The end-of-word peek is folded into the last mark so the trailing gap is exactly word_time.
      MARK: if (phase_end) begin
        if (left_reg == LEN_W'(1)) state_next = peek_end ? GAP_WORD : GAP_CHAR;
        else                       state_next = GAP_SYM;
      end
      GAP_SYM: if (phase_end) begin
        pat_next   = pat_reg >> 1;
        left_next  = left_reg - LEN_W'(1);
        state_next = MARK;
      end
      GAP_CHAR: if (phase_end) begin
        idx_next   = idx_inc;
        state_next = LOAD;
      end
      GAP_WORD: if (phase_end) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      idx_reg    <= '0;
      pat_reg    <= '0;
      left_reg   <= '0;
      cnt_reg    <= '0;
      sent_reg   <= 1'b0;
      error_reg  <= 1'b0;
      signal_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      word_reg   <= word_next;
      idx_reg    <= idx_next;
      pat_reg    <= pat_next;
      left_reg   <= left_next;
      cnt_reg    <= cnt_next;
      sent_reg   <= sent_next;
      error_reg  <= error_next;
      signal_reg <= (state_next == MARK);
    end
  end

  assign signal = signal_reg;
  assign error  = error_reg;
  assign done   = (state_reg == DONE);
  assign busy   = (state_reg != IDLE) && (state_reg != DONE);

endmodule

// File: tb/tb_morse_encode_word_tx.sv
// Directed bench for morse_encode_word_tx: each word's keyed output is reduced to run lengths
// (low/high alternating, starting with the one-clk LOAD low) and compared to hand-derived lists.
module tb_morse_encode_word_tx;

  logic        clk = 1'b0;
  logic        aclr, ce, start;
  logic [15:0] dit_time, dah_time, word_time;
  logic [63:0] word_in;
  logic        busy, signal, done, error;

  int vec_count   = 0;
  int miscompares = 0;
  int exp_q[$];

  morse_encode_word_tx dut (
    .clk(clk), .aclr(aclr), .ce(ce),
    .dit_time(dit_time), .dah_time(dah_time), .word_time(word_time),
    .word(word_in), .start(start),
    .busy(busy), .signal(signal), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word and compares signal run lengths against exp_q.
  task automatic send(input string name, input logic [63:0] w, input bit ce_tog, input bit poke);
    int  runs[$];
    int  run_len;
    bit  level;
    bit  got_done;
    word_in = w;
    start   = 1'b1;
    ce      = ce_tog ? 1'b0 : 1'b1;
    tick();
    start   = 1'b0;
    check({name, " busy_after_accept"}, busy, 1);
    level    = 1'b0;
    run_len  = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (signal == level) run_len++;
        else begin
          runs.push_back(run_len);
          level   = signal;
          run_len = 1;
        end
        ce = ce_tog ? ((cyc % 2) == 0) : 1'b1;
        if (poke && cyc == 3) begin
          start   = 1'b1;
          word_in = 64'h545454;
        end
        if (poke && cyc == 4) start = 1'b0;
        tick();
      end
    end
    runs.push_back(run_len);
    check({name, " done_seen"}, got_done, 1);
    check({name, " busy_at_done"}, busy, 0);
    check({name, " signal_at_done"}, signal, 0);
    check({name, " run_count"}, runs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < runs.size(); i++)
      check($sformatf("%s run%0d", name, i), runs[i], exp_q[i]);
    ce = 1'b1;
    tick();
    check({name, " done_pulse_ends"}, done, 0);
    check({name, " idle_after"}, busy, 0);
    $display("word %s: %0d runs checked", name, runs.size());
  endtask

  initial begin
    int done_seen;
    aclr = 1'b1; ce = 1'b1; start = 1'b0; word_in = '0;
    dit_time = 16'd2; dah_time = 16'd6; word_time = 16'd14;
    repeat (3) tick();
    check("reset signal", signal, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    aclr = 1'b0;
    tick();

    exp_q = '{1, 2, 14};
    send("E", 64'h45, 1'b0, 1'b0);
    check("E error", error, 0);

    exp_q = '{1, 2, 2, 6, 14};
    send("A", 64'h41, 1'b0, 1'b0);

    exp_q = '{1, 2, 7, 6, 14};
    send("ET", 64'h5445, 1'b0, 1'b0);

    exp_q = '{1, 2, 8, 2, 14};
    send("E#E", 64'h452345, 1'b0, 1'b0);
    check("E#E error sticky", error, 1);

    exp_q = '{1, 2, 14};
    send("E_clear", 64'h45, 1'b0, 1'b0);
    check("error cleared", error, 0);

    exp_q = '{1, 4, 28};
    send("E_ce_toggle", 64'h45, 1'b1, 1'b0);

    exp_q = '{1};
    send("empty", 64'h0, 1'b0, 1'b0);
    check("empty error", error, 0);

    exp_q = '{1, 2, 14};
    send("E_busy_start", 64'h45, 1'b0, 1'b1);

    exp_q = '{1};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(2);
      exp_q.push_back(i == 7 ? 14 : 7);
    end
    send("EEEEEEEE", 64'h4545454545454545, 1'b0, 1'b0);

    dit_time = 16'd0;
    exp_q = '{1, 1, 14};
    send("E_dit0", 64'h45, 1'b0, 1'b0);
    dit_time = 16'd2;

    // Reset during the third mark cycle of "T", with a start presented alongside it.
    word_in = 64'h54; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("T first mark", signal, 1);
    tick();
    tick();
    check("T third mark", signal, 1);
    aclr = 1'b1; start = 1'b1;
    tick();
    check("abort signal", signal, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    aclr = 1'b0; start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("abort no done/busy", done_seen, 0);

    exp_q = '{1, 6, 14};
    send("T_after_abort", 64'h54, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
